rgb2attr_encoder: RTL and testbench

Converts a pair of 24-bit RGB colours (foreground, background) plus a blink flag into one 8-bit VGA text-mode attribute byte. It is the inverse of the attribute-to-RGB palette lookup. It sits between a software- or DMA-driven pixel/colour source and the text-buffer write path of the HDMI text console. Each colour is mapped to its nearest 16-colour VGA palette entry by a sequential distance search, one palette entry per clock. Input and output use valid/ready handshakes.

---
 rtl/rgb2attr_encoder.sv | 192 +++++++++++++++++++
 tb/tb_rgb2attr_encoder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rgb2attr_encoder.sv
// rgb2attr_encoder
// ----------------
// Converts a foreground/background RGB colour pair plus a blink flag into a
// VGA text-mode attribute byte {blink/bright-bg, bg[2:0], fg[3:0]}. Each
// colour is matched to the nearest entry of the 16-colour VGA palette using a
// sequential Manhattan-distance search, one palette entry per clock.
//
// Ports:
//   clk        system clock, rising-edge active
//   rst_n      asynchronous active-low reset
//   in_valid   input colour pair valid
//   in_ready   block can accept a new colour pair (only in IDLE)
//   in_fg      foreground colour {R,G,B}, 8 bits per channel
//   in_bg      background colour {R,G,B}
//   in_blink   blink request
//   out_valid  attribute byte valid
//   out_ready  downstream accepts the attribute byte
//   out_attr   attribute byte
//
// Configuration macro: RGB2ATTR_BRIGHT_BG_EN
//   defined   - background searches all 16 entries, out_attr[7] = bg[3],
//               in_blink is ignored (bright-background mode)
//   undefined - background searches entries 0-7, out_attr[7] = blink

module rgb2attr_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] in_fg,
    input  logic [23:0] in_bg,
    input  logic        in_blink,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_attr
);

    typedef enum logic [1:0] {
        IDLE,
        SFG,
        SBG,
        DONE
    } state_t;

`ifdef RGB2ATTR_BRIGHT_BG_EN
    localparam logic [3:0] BG_LAST = 4'd15;
`else
    localparam logic [3:0] BG_LAST = 4'd7;
`endif

    localparam logic [9:0] DIST_INIT = 10'h3FF;

    state_t      state;
    logic [23:0] fg_q;
    logic [23:0] bg_q;
    logic        blink_q;
    logic [3:0]  idx;
    logic [3:0]  best_idx;
    logic [9:0]  best_dist;
    logic [3:0]  fg_idx;

    logic [23:0] target;
    logic [9:0]  cand_dist;
    logic [3:0]  next_best_idx;
    logic [9:0]  next_best_dist;

    // Standard VGA 16-colour palette.
    function automatic logic [23:0] palette(input logic [3:0] i);
        logic [23:0] c;
        case (i)
            4'h0: c = 24'h000000;
            4'h1: c = 24'h0000AA;
            4'h2: c = 24'h00AA00;
            4'h3: c = 24'h00AAAA;
            4'h4: c = 24'hAA0000;
            4'h5: c = 24'hAA00AA;
            4'h6: c = 24'hAA5500;
            4'h7: c = 24'hAAAAAA;
            4'h8: c = 24'h555555;
            4'h9: c = 24'h5555FF;
            4'hA: c = 24'h55FF55;
            4'hB: c = 24'h55FFFF;
            4'hC: c = 24'hFF5555;
            4'hD: c = 24'hFF55FF;
            4'hE: c = 24'hFFFF55;
            default: c = 24'hFFFFFF;
        endcase
        return c;
    endfunction

    function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // Sum of three 8-bit terms fits in 10 bits, so it can never overflow.
    function automatic logic [9:0] distance(input logic [23:0] a, input logic [23:0] b);
        return {2'b00, abs_diff(a[23:16], b[23:16])}
             + {2'b00, abs_diff(a[15:8],  b[15:8])}
             + {2'b00, abs_diff(a[7:0],   b[7:0])};
    endfunction

    // Distance of the current palette entry to whichever colour is being
    // searched. Strict less-than keeps the lowest index on a tie.
    always_comb begin
        target         = (state == SBG) ? bg_q : fg_q;
        cand_dist      = distance(target, palette(idx));
        next_best_idx  = best_idx;
        next_best_dist = best_dist;
        if (cand_dist < best_dist) begin
            next_best_idx  = idx;
            next_best_dist = cand_dist;
        end
    end

    // Control FSM with registered handshake outputs. The final search step
    // of each colour uses the combinational next-best values so the last
    // palette entry is included in the stored result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_attr  <= 8'h00;
            fg_q      <= 24'h000000;
            bg_q      <= 24'h000000;
            blink_q   <= 1'b0;
            idx       <= 4'd0;
            best_idx  <= 4'd0;
            best_dist <= DIST_INIT;
            fg_idx    <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        fg_q      <= in_fg;
                        bg_q      <= in_bg;
                        blink_q   <= in_blink;
                        idx       <= 4'd0;
                        best_idx  <= 4'd0;
                        best_dist <= DIST_INIT;
                        in_ready  <= 1'b0;
                        state     <= SFG;
                    end else begin
                        in_ready  <= 1'b1;
                    end
                end
                SFG: begin
                    if (idx == 4'd15) begin
                        fg_idx    <= next_best_idx;
                        idx       <= 4'd0;
                        best_idx  <= 4'd0;
                        best_dist <= DIST_INIT;
                        state     <= SBG;
                    end else begin
                        best_idx  <= next_best_idx;
                        best_dist <= next_best_dist;
                        idx       <= idx + 4'd1;
                    end
                end
                SBG: begin
                    if (idx == BG_LAST) begin
`ifdef RGB2ATTR_BRIGHT_BG_EN
                        out_attr  <= {next_best_idx, fg_idx};
`else
                        out_attr  <= {blink_q, next_best_idx[2:0], fg_idx};
`endif
                        out_valid <= 1'b1;
                        idx       <= 4'd0;
                        best_idx  <= 4'd0;
                        best_dist <= DIST_INIT;
                        state     <= DONE;
                    end else begin
                        best_idx  <= next_best_idx;
                        best_dist <= next_best_dist;
                        idx       <= idx + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rgb2attr_encoder.sv
// tb_rgb2attr_encoder
// -------------------
// Self-checking bench for rgb2attr_encoder: directed colour vectors with
// hand-computed attribute bytes, plus backpressure, mid-search reset and
// early out_ready sequences. Expected values follow the build configuration
// (RGB2ATTR_BRIGHT_BG_EN).

module tb_rgb2attr_encoder;

`ifdef RGB2ATTR_BRIGHT_BG_EN
    localparam int LAT = 32;
`else
    localparam int LAT = 24;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_fg;
    logic [23:0] in_bg;
    logic        in_blink;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_attr;

    typedef struct {
        logic [23:0] fg;
        logic [23:0] bg;
        logic        blink;
        logic [7:0]  attr;
    } vec_t;

    vec_t vecs[9];
    int   tests = 0;
    int   fails = 0;

    rgb2attr_encoder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_fg    (in_fg),
        .in_bg    (in_bg),
        .in_blink (in_blink),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_attr (out_attr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Waits (bounded) for in_ready, presents one colour pair for a single
    // accepting edge, scrambles the inputs afterwards and returns the number
    // of edges from the accept edge until out_valid is seen.
    task automatic applyStimulus(input logic [23:0] fg, input logic [23:0] bg,
                                 input logic blink, output int lat);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        checkOutput("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_fg    = fg;
        in_bg    = bg;
        in_blink = blink;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_fg    = ~fg;
        in_bg    = ~bg;
        in_blink = ~blink;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Full transaction with immediate handshake.
    task automatic runVector(input string name, input vec_t v);
        int lat;
        applyStimulus(v.fg, v.bg, v.blink, lat);
        checkOutput({name, "_latency"}, lat, LAT);
        checkOutput({name, "_attr"}, {24'd0, out_attr}, {24'd0, v.attr});
        checkOutput({name, "_in_ready_done"}, {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput({name, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
        checkOutput({name, "_in_ready_back"}, {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;

        vecs[0] = '{24'hFFFFFF, 24'h000000, 1'b0, 8'h0F};
        vecs[3] = '{24'h00AA00, 24'h000000, 1'b0, 8'h02};
        vecs[7] = '{24'hFF55FF, 24'h00AAAA, 1'b0, 8'h3D};
        vecs[8] = '{24'h60FF50, 24'hA00000, 1'b0, 8'h4A};
`ifdef RGB2ATTR_BRIGHT_BG_EN
        vecs[1] = '{24'hAA5500, 24'h0000AA, 1'b1, 8'h16};
        vecs[2] = '{24'h000055, 24'hFF5555, 1'b0, 8'hC0};
        vecs[4] = '{24'h000000, 24'hFFFFFF, 1'b0, 8'hF0};
        vecs[5] = '{24'h000000, 24'hFFFFFF, 1'b1, 8'hF0};
        vecs[6] = '{24'h5555FF, 24'hAAAAAA, 1'b1, 8'h79};
`else
        vecs[1] = '{24'hAA5500, 24'h0000AA, 1'b1, 8'h96};
        vecs[2] = '{24'h000055, 24'hFF5555, 1'b0, 8'h60};
        vecs[4] = '{24'h000000, 24'hFFFFFF, 1'b0, 8'h70};
        vecs[5] = '{24'h000000, 24'hFFFFFF, 1'b1, 8'hF0};
        vecs[6] = '{24'h5555FF, 24'hAAAAAA, 1'b1, 8'hF9};
`endif

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_fg     = 24'h0;
        in_bg     = 24'h0;
        in_blink  = 1'b0;
        out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_out_attr", {24'd0, out_attr}, 32'd0);
        checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("release_in_ready", {31'd0, in_ready}, 32'd1);

        // Table-driven vectors
        for (int i = 0; i < 9; i++) begin
            runVector($sformatf("vec%0d", i), vecs[i]);
        end

        // Backpressure: hold DONE for 10 cycles while poking in_valid
        applyStimulus(vecs[1].fg, vecs[1].bg, vecs[1].blink, lat);
        checkOutput("bp_latency", lat, LAT);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            in_valid = (k % 2 == 0);
            in_fg    = 24'hFFFFFF;
            in_bg    = 24'hFFFFFF;
            @(posedge clk);
            #1;
            checkOutput($sformatf("bp_valid_%0d", k), {31'd0, out_valid}, 32'd1);
            checkOutput($sformatf("bp_attr_%0d", k), {24'd0, out_attr}, {24'd0, vecs[1].attr});
            checkOutput($sformatf("bp_in_ready_%0d", k), {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("bp_release_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("bp_idle_hold", {31'd0, in_ready}, 32'd1);

        // Reset mid-search at E10
        @(negedge clk);
        in_valid = 1'b1;
        in_fg    = 24'hFFFFFF;
        in_bg    = 24'hAAAAAA;
        in_blink = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("midrst_out_attr", {24'd0, out_attr}, 32'd0);
        checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst_release_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (30) @(posedge clk);
        #1;
        checkOutput("midrst_no_output", {31'd0, out_valid}, 32'd0);
        runVector("midrst_next", vecs[3]);

        // out_ready held high through the search: one-cycle out_valid pulse
        @(negedge clk);
        out_ready = 1'b1;
        applyStimulus(vecs[7].fg, vecs[7].bg, vecs[7].blink, lat);
        checkOutput("early_ready_latency", lat, LAT);
        checkOutput("early_ready_attr", {24'd0, out_attr}, {24'd0, vecs[7].attr});
        @(posedge clk);
        #1;
        checkOutput("early_ready_valid_drop", {31'd0, out_valid}, 32'd0);
        checkOutput("early_ready_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        out_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
